// File: rtl/vga_timing_rx.sv
// VGA timing receiver: recovers col/row/active from hSync/vSync on pClk ticks and tracks lock to HTOTAL/VTOTAL.
// Outputs register one clk50 cycle after each tick; non-tick cycles freeze all state and clear the pulses.
module vga_timing_rx #(
  parameter int HBACK   = 48,
  parameter int HACTIVE = 640,
  parameter int HTOTAL  = 800,
  parameter int VBACK   = 33,
  parameter int VACTIVE = 480,
  parameter int VTOTAL  = 525
) (
  input  logic        clk50,
  input  logic        reset,
  input  logic        pClk,
  input  logic        hSync,
  input  logic        vSync,
  output logic [9:0]  col,
  output logic [8:0]  row,
  output logic        active,
  output logic        col0,
  output logic        row0,
  output logic [11:0] lineLen,
  output logic [10:0] frameLines,
  output logic        locked,
  output logic        error
);

  localparam logic [11:0] H_LO  = 12'(HBACK);
  localparam logic [11:0] H_HI  = 12'(HBACK + HACTIVE);
  localparam logic [11:0] H_TOT = 12'(HTOTAL);
  localparam logic [10:0] V_LO  = 11'(VBACK);
  localparam logic [10:0] V_HI  = 11'(VBACK + VACTIVE);
  localparam logic [10:0] V_TOT = 11'(VTOTAL);

  typedef enum logic [1:0] {UNLOCKED, ACQUIRE, LOCKED} lock_e;

  // Reset asserts asynchronously but is released on a clk50 edge.
  logic [1:0] rst_sync_q;
  logic       rst_n;

  always_ff @(posedge clk50 or negedge reset) begin
    if (!reset) rst_sync_q <= 2'b00;
    else        rst_sync_q <= {rst_sync_q[0], 1'b1};
  end

  assign rst_n = rst_sync_q[1];

  lock_e       state_q;
  logic        hs_q, vs_q, vpend_q, bad_q;
  logic [11:0] hcnt_q, hcnt_d, len_meas;
  logic [10:0] vcnt_q, vcnt_d, lines_meas;
  logic [9:0]  col_d;
  logic [8:0]  row_d;
  logic        hs_rise, vs_rise, restart, line_good, frame_good, vtot_hit, in_win;

  assign hs_rise    = hSync & ~hs_q;
  assign vs_rise    = vSync & ~vs_q;
  // A vSync edge on the same tick as the hSync edge already counts as pending.
  assign restart    = hs_rise & (vpend_q | vs_rise);
  assign len_meas   = hcnt_q + 12'd1;
  assign lines_meas = vcnt_q + 11'd1;
  assign hcnt_d     = hs_rise ? 12'd0 : ((&hcnt_q) ? hcnt_q : len_meas);
  assign vcnt_d     = restart ? 11'd0 : ((hs_rise && !(&vcnt_q)) ? lines_meas : vcnt_q);
  assign line_good  = (len_meas == H_TOT);
  assign frame_good = line_good && !bad_q && (lines_meas == V_TOT);
  assign vtot_hit   = hs_rise && !restart && (vcnt_d == V_TOT);
  assign in_win     = (hcnt_d >= H_LO) && (hcnt_d < H_HI) && (vcnt_d >= V_LO) && (vcnt_d < V_HI);
  assign col_d      = 10'(hcnt_d - H_LO);
  assign row_d      = 9'(vcnt_d - V_LO);

  always_ff @(posedge clk50 or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= UNLOCKED;
      hs_q       <= 1'b1;
      vs_q       <= 1'b1;
      vpend_q    <= 1'b0;
      bad_q      <= 1'b0;
      hcnt_q     <= 12'hFFF;
      vcnt_q     <= 11'h7FF;
      col        <= '0;
      row        <= '0;
      active     <= 1'b0;
      col0       <= 1'b0;
      row0       <= 1'b0;
      lineLen    <= '0;
      frameLines <= '0;
      locked     <= 1'b0;
      error      <= 1'b0;
    end else if (pClk) begin
      hs_q   <= hSync;
      vs_q   <= vSync;
      hcnt_q <= hcnt_d;
      vcnt_q <= vcnt_d;
      active <= in_win;
      col    <= in_win ? col_d : '0;
      row    <= in_win ? row_d : '0;
      col0   <= in_win && (col_d == '0);
      row0   <= in_win && (col_d == '0) && (row_d == '0);
      error  <= 1'b0;
      if (hs_rise) lineLen <= len_meas;
      if (restart) begin
        frameLines <= lines_meas;
        vpend_q    <= 1'b0;
        bad_q      <= 1'b0;
      end else begin
        if (vs_rise) vpend_q <= 1'b1;
        if (hs_rise && !line_good) bad_q <= 1'b1;
      end
      // The line ending on the restart edge belongs to the frame being judged.
      if (hs_rise) begin
        case (state_q)
          UNLOCKED: if (restart && frame_good) state_q <= ACQUIRE;
          ACQUIRE: if (restart) begin
            state_q <= frame_good ? LOCKED : UNLOCKED;
            locked  <= frame_good;
          end
          LOCKED: if (!line_good || vtot_hit || (restart && !frame_good)) begin
            state_q <= UNLOCKED;
            locked  <= 1'b0;
            error   <= 1'b1;
          end
          default: begin
            state_q <= UNLOCKED;
            locked  <= 1'b0;
          end
        endcase
      end
    end else begin
      col0  <= 1'b0;
      row0  <= 1'b0;
      error <= 1'b0;
    end
  end

endmodule

// File: tb/tb_vga_timing_rx.sv
// Directed bench for vga_timing_rx using a scaled-down raster (20 ticks x 10 lines) with hand-computed expectations.
module tb_vga_timing_rx;

  localparam int HB = 4, HA = 8, HT = 20, VB = 2, VA = 4, VT = 10, HS = 3;

  logic        clk50 = 1'b0;
  logic        reset, pClk, hSync, vSync;
  logic [9:0]  col;
  logic [8:0]  row;
  logic        active, col0, row0, locked, error;
  logic [11:0] lineLen;
  logic [10:0] frameLines;

  vga_timing_rx #(
    .HBACK(HB), .HACTIVE(HA), .HTOTAL(HT), .VBACK(VB), .VACTIVE(VA), .VTOTAL(VT)
  ) dut (
    .clk50(clk50), .reset(reset), .pClk(pClk), .hSync(hSync), .vSync(vSync),
    .col(col), .row(row), .active(active), .col0(col0), .row0(row0),
    .lineLen(lineLen), .frameLines(frameLines), .locked(locked), .error(error)
  );

  always #5 clk50 = ~clk50;

  int errors = 0, checks = 0, frame_no = 0;
  int act_cnt = 0, col0_cnt = 0, row0_cnt = 0, err_cnt = 0;
  int row0_l = -1, row0_t = -1, row0_c = -1, row0_r = -1, row0_c0 = -1;
  int last_col = -1, last_row = -1;
  int err_f = -1, err_l = -1, err_t = -1, err_len = -1;
  int lock_f = -1, lock_l = -1, lock_t = -1;
  int unl_f = -1, unl_l = -1, unl_t = -1;
  logic lock_prev = 1'b0;

  task automatic check(input string tag, input int got, input int exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // One pixel tick: pClk high for one clk50 cycle, then low for one.
  task automatic tick(input logic h, input logic v);
    @(negedge clk50);
    pClk = 1'b1; hSync = h; vSync = v;
    @(negedge clk50);
    pClk = 1'b0;
  endtask

  task automatic observe(input int l, input int t);
    if (active) begin
      act_cnt++;
      last_col = int'(col);
      last_row = int'(row);
    end
    if (col0) col0_cnt++;
    if (locked && !lock_prev) begin lock_f = frame_no; lock_l = l; lock_t = t; end
    if (!locked && lock_prev) begin unl_f = frame_no; unl_l = l; unl_t = t; end
    lock_prev = locked;
    if (row0) begin
      row0_cnt++;
      row0_l = l; row0_t = t; row0_c = int'(col); row0_r = int'(row); row0_c0 = int'(col0);
      @(posedge clk50); #1;
      check("row0_clear", int'(row0), 0);
      check("col0_clear", int'(col0), 0);
    end
    if (error) begin
      err_cnt++;
      err_f = frame_no; err_l = l; err_t = t; err_len = int'(lineLen);
      @(posedge clk50); #1;
      check("error_clear", int'(error), 0);
    end
  endtask

  task automatic send_frame(input int long_line, input bit no_vs, input int freeze_line, input int rst_line);
    act_cnt = 0; col0_cnt = 0; row0_cnt = 0;
    for (int l = 0; l < VT; l++) begin
      int len;
      len = (l == long_line) ? HT + 1 : HT;
      for (int t = 0; t < len; t++) begin
        tick(t >= HS, no_vs || l >= 2);
        observe(l, t);
        if (l == freeze_line && t == 7) begin
          repeat (10) @(posedge clk50);
          @(negedge clk50);
          check("frz_col", int'(col), 0);
          check("frz_row", int'(row), 1);
          check("frz_active", int'(active), 1);
          check("frz_col0", int'(col0), 0);
          check("frz_lineLen", int'(lineLen), HT);
        end
        if (l == rst_line && t == 10) begin
          check("pre_rst_col", int'(col), 3);
          check("pre_rst_row", int'(row), 1);
          check("pre_rst_locked", int'(locked), 1);
          #2 reset = 1'b0;
          #1;
          check("rst_active", int'(active), 0);
          check("rst_col", int'(col), 0);
          check("rst_row", int'(row), 0);
          check("rst_lineLen", int'(lineLen), 0);
          check("rst_frameLines", int'(frameLines), 0);
          check("rst_locked", int'(locked), 0);
          repeat (2) @(negedge clk50);
          reset = 1'b1;
          repeat (3) @(negedge clk50);
        end
      end
    end
    frame_no++;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1);
  end

  initial begin
    reset = 1'b1; pClk = 1'b0; hSync = 1'b1; vSync = 1'b1;
    #1 reset = 1'b0;
    repeat (5) @(negedge clk50);
    check("reset_col", int'(col), 0);
    check("reset_row", int'(row), 0);
    check("reset_active", int'(active), 0);
    check("reset_col0", int'(col0), 0);
    check("reset_row0", int'(row0), 0);
    check("reset_lineLen", int'(lineLen), 0);
    check("reset_frameLines", int'(frameLines), 0);
    check("reset_locked", int'(locked), 0);
    check("reset_error", int'(error), 0);
    reset = 1'b1;
    repeat (3) @(negedge clk50);

    // Frame 0 is partial from reset, frames 1 and 2 acquire then lock.
    send_frame(-1, 1'b0, -1, -1);
    check("f0_lineLen", int'(lineLen), 20);
    check("f0_frameLines", int'(frameLines), 0);
    check("f0_locked", int'(locked), 0);
    send_frame(-1, 1'b0, -1, -1);
    check("f1_frameLines", int'(frameLines), 10);
    check("f1_locked", int'(locked), 0);
    send_frame(-1, 1'b0, -1, -1);
    check("f2_locked", int'(locked), 1);
    check("f2_lock_frame", lock_f, 2);
    check("f2_lock_line", lock_l, 2);
    check("f2_lock_tick", lock_t, 3);
    check("f2_active_ticks", act_cnt, 32);
    check("f2_col0_cnt", col0_cnt, 4);
    check("f2_row0_cnt", row0_cnt, 1);
    check("f2_row0_line", row0_l, 4);
    check("f2_row0_tick", row0_t, 7);
    check("f2_row0_col", row0_c, 0);
    check("f2_row0_row", row0_r, 0);
    check("f2_row0_col0", row0_c0, 1);
    check("f2_last_col", last_col, 7);
    check("f2_last_row", last_row, 3);
    check("f2_err_cnt", err_cnt, 0);

    // One 21-tick line while locked.
    send_frame(5, 1'b0, -1, -1);
    check("f3_err_cnt", err_cnt, 1);
    check("f3_err_frame", err_f, 3);
    check("f3_err_line", err_l, 6);
    check("f3_err_tick", err_t, 3);
    check("f3_err_len", err_len, 21);
    check("f3_unlock_line", unl_l, 6);
    check("f3_unlock_tick", unl_t, 3);
    check("f3_locked", int'(locked), 0);
    send_frame(-1, 1'b0, -1, -1);
    send_frame(-1, 1'b0, -1, -1);
    check("f5_locked", int'(locked), 0);
    send_frame(-1, 1'b0, 5, -1);
    check("f6_lock_frame", lock_f, 6);
    check("f6_lock_line", lock_l, 2);
    check("f6_active_ticks", act_cnt, 32);
    check("f6_locked", int'(locked), 1);

    // hSync stalled high long enough to saturate the line counter.
    for (int i = 0; i < 4300; i++) begin
      tick(1'b1, 1'b1);
      observe(-1, i);
    end
    check("stall_active", int'(active), 0);
    check("stall_col", int'(col), 0);
    check("stall_locked", int'(locked), 1);
    check("stall_lineLen", int'(lineLen), 20);
    check("stall_err_cnt", err_cnt, 1);
    send_frame(-1, 1'b0, -1, -1);
    check("f7_err_cnt", err_cnt, 2);
    check("f7_err_frame", err_f, 7);
    check("f7_err_line", err_l, 0);
    check("f7_err_len", err_len, 0);
    check("f7_frameLines", int'(frameLines), 10);
    send_frame(-1, 1'b0, -1, -1);
    send_frame(-1, 1'b0, -1, -1);
    check("f9_lock_frame", lock_f, 9);

    // Missing vSync: line count reaches VT without a frame restart.
    send_frame(-1, 1'b1, -1, -1);
    check("f10_err_cnt", err_cnt, 3);
    check("f10_err_frame", err_f, 10);
    check("f10_err_line", err_l, 2);
    check("f10_err_tick", err_t, 3);
    check("f10_locked", int'(locked), 0);
    send_frame(-1, 1'b0, -1, -1);
    check("f11_frameLines", int'(frameLines), 20);
    send_frame(-1, 1'b0, -1, -1);
    send_frame(-1, 1'b0, -1, -1);
    check("f13_lock_frame", lock_f, 13);

    // Reset mid active line, then two good frames to relock.
    send_frame(-1, 1'b0, -1, 5);
    check("f14_lineLen", int'(lineLen), 20);
    check("f14_frameLines", int'(frameLines), 0);
    check("f14_locked", int'(locked), 0);
    send_frame(-1, 1'b0, -1, -1);
    send_frame(-1, 1'b0, -1, -1);
    check("f16_locked", int'(locked), 0);
    check("f16_frameLines", int'(frameLines), 10);
    send_frame(-1, 1'b0, -1, -1);
    check("f17_lock_frame", lock_f, 17);
    check("f17_locked", int'(locked), 1);
    check("final_err_cnt", err_cnt, 3);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/vga_timing_rx.md
VGA_TIMING_RX -- requirements
Module: vga_timing_rx

Interface
REQ-001 SHALL provide parameter HBACK, 48, pixel ticks from hSync rising edge to first active column.
REQ-002 SHALL provide parameter HACTIVE, 640, active columns per line.
REQ-003 SHALL provide parameter HTOTAL, 800, expected pixel ticks per line.
REQ-004 SHALL provide parameter VBACK, 33, lines from vSync rising edge to first active row.
REQ-005 SHALL provide parameter VACTIVE, 480, active rows per frame.
REQ-006 SHALL provide parameter VTOTAL, 525, expected lines per frame.
REQ-007 SHALL have ports, one per line:
- clk50  in  1  system clock, all logic on rising edge
- reset  in  1  asynchronous, active-low reset
- pClk  in  1  pixel tick enable; a clk50 cycle with pClk=1 is a "tick"
- hSync  in  1  horizontal sync, active-low pulse
- vSync  in  1  vertical sync, active-low pulse
- col  out  10  current active column, 0..HACTIVE-1, else 0
- row  out  9  current active row, 0..VACTIVE-1, else 0
- active  out  1  high while pixel lies in active window
- col0  out  1  one-tick pulse at column 0 of every active row
- row0  out  1  one-tick pulse at column 0 of row 0
- lineLen  out  12  ticks measured in last complete line
- frameLines  out  11  lines measured in last complete frame
- locked  out  1  timing matches HTOTAL/VTOTAL
- error  out  1  one-tick pulse on loss of lock

Function
REQ-008 SHALL sample hSync/vSync into hsR/vsR only on ticks; edge detection compares each sample with the previous tick's sample.
REQ-009 SHALL hold all registers unchanged on non-tick cycles; col0, row0, error SHALL be cleared on the first non-tick cycle.
REQ-010 SHALL keep hCnt[11:0]: on a tick with hSync rising edge, hCnt<=0 and lineLen<=hCnt+1; otherwise hCnt+1, saturating at 4095.
REQ-011 SHALL keep vCnt[10:0]: on each hSync rising edge, vCnt+1, saturating at 2047; on the first hSync rising edge at or after a vSync rising edge, vCnt<=0 and frameLines<=vCnt+1.
REQ-012 SHALL evaluate hSync and vSync rising edges on the same tick with the vSync edge registered first, so that hSync edge restarts the frame.
REQ-013 SHALL assert active iff HBACK<=hCnt<HBACK+HACTIVE and VBACK<=vCnt<VBACK+VACTIVE, evaluated on the updated counters, registered, one clk50 cycle after the tick.
REQ-014 SHALL drive col=hCnt-HBACK, row=vCnt-VBACK (truncated) while active, else 0.
REQ-015 SHALL pulse col0 when active and col==0; row0 when additionally row==0.
REQ-016 SHALL implement lock FSM UNLOCKED -> ACQUIRE -> LOCKED, updated at each frame restart (REQ-011):
- UNLOCKED: frameLines==VTOTAL and every line in frame had lineLen==HTOTAL -> ACQUIRE
- ACQUIRE: next frame likewise good -> LOCKED; any bad -> UNLOCKED
- LOCKED: locked=1; held while frames good
REQ-017 SHALL, in LOCKED, on any line with lineLen!=HTOTAL, or vCnt reaching VTOTAL without frame restart, go to UNLOCKED, pulse error, clear locked on the same tick.
REQ-018 SHALL track per-frame "all lines good" in a flag cleared at each frame restart.
REQ-019 SHALL NOT gate col/row/active by locked; they follow counters always.
REQ-020 SHALL treat hSync/vSync as synchronous to clk50 (no internal synchronizer).

Reset
REQ-021 SHALL, while reset=0, force hCnt=4095, vCnt=2047, hsR=vsR=1, FSM=UNLOCKED, all outputs 0 (lineLen=0, frameLines=0).
REQ-022 SHALL apply reset asynchronously, release synchronously to clk50; reset mid-frame discards partial line/frame measurements.

Verification
REQ-023 Drive standard 640x480 timing (96/48/640/16, 2/33/480/10, pClk every other cycle) -> lineLen=800, frameLines=525; locked=1 after frame restart ending 2nd full frame; active duty 307200 ticks/frame.
REQ-024 In locked stream, first pixel after 48 back-porch ticks on line 33 after vSync -> col=0,row=0,col0=1,row0=1 for one tick; last active pixel col=639,row=479.
REQ-025 Lengthen one line to 801 ticks while locked -> error one tick, locked=0 at that line's hSync edge; two further good frames -> locked=1.
REQ-026 Stop hSync toggling -> hCnt saturates at 4095, active=0, no counter wrap; locked drops via VTOTAL check only if hSync edges continue, otherwise holds until next edge.
REQ-027 Assert reset=0 mid-active-line -> all outputs 0 immediately (asynchronous); after release, locked requires two full good frames.
REQ-028 Hold pClk=0 for 10 cycles mid-line -> all outputs and counters frozen, col0/row0/error low.
